// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console byte interpreter.
package text_pkg;

  // Default screen geometry and tab spacing.
  localparam int COLS_DEF  = 80;
  localparam int ROWS_DEF  = 30;
  localparam int TAB_W_DEF = 8;

  // Counter and character widths on the display write port.
  localparam int X_W   = 7;
  localparam int Y_W   = 6;
  localparam int CHR_W = 9;

  // Control codes interpreted by the console.
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // ST_RESET is held only while reset is asserted and for the first clock after release.
  typedef enum logic [1:0] {
    ST_RESET      = 2'd0,
    ST_IDLE       = 2'd1,
    ST_CLR_LINE   = 2'd2,
    ST_CLR_SCREEN = 2'd3
  } console_state_t;

  // Bytes 0x20..0x7E are written to the screen as glyphs.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte input handshake, display cell-write port and cursor status of the text console.
//
// Handshake: a byte moves from source to console on a rising clk_sys edge where
// in_valid and in_ready are both high. in_data only needs to be stable around that
// edge. in_ready does not depend on in_valid. char_str is a one-cycle write strobe
// with no back-pressure; char_x/char_y/char_chr are meaningful only while it is high.
interface text_console_if;
  import text_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;

  logic [X_W-1:0]   char_x;
  logic [Y_W-1:0]   char_y;
  logic [CHR_W-1:0] char_chr;
  logic             char_str;

  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic             busy;

  console_state_t   dbg_state;

  // Console side: consumes bytes, drives the display port and status.
  modport slave (
    input  in_data, in_valid,
    output in_ready, char_x, char_y, char_chr, char_str, cur_x, cur_y, busy, dbg_state
  );

  // Byte source / display side.
  modport master (
    output in_data, in_valid,
    input  in_ready, char_x, char_y, char_chr, char_str, cur_x, cur_y, busy, dbg_state
  );

endinterface

// File: rtl/text_console.sv
// Terminal-style byte interpreter: keeps a cursor, turns printable bytes into cell
// writes and sequences line/screen clears as runs of space writes.
module text_console
  import text_pkg::*;
#(
  parameter int COLS       = COLS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int TAB_W      = TAB_W_DEF,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          clk_sys,
  input  logic          btn_rst_n,
  text_console_if.slave con
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(COLS - 1);
  localparam logic [X_W-1:0] X_END    = X_W'(COLS);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(ROWS - 1);
  localparam logic [Y_W-1:0] Y_END    = Y_W'(ROWS);
  localparam logic [7:0]     TAB_MASK = 8'(TAB_W - 1);
  localparam logic [7:0]     COLS_8   = 8'(COLS);

  console_state_t   state_q, state_d;

  logic [X_W-1:0]   cur_x_q, cur_x_d;
  logic [Y_W-1:0]   cur_y_q, cur_y_d;
  // Clear sequencer position; one past the last cell marks "all strobes issued".
  logic [X_W-1:0]   clr_x_q, clr_x_d;
  logic [Y_W-1:0]   clr_y_q, clr_y_d;

  logic [X_W-1:0]   char_x_q, char_x_d;
  logic [Y_W-1:0]   char_y_q, char_y_d;
  logic [CHR_W-1:0] char_chr_q, char_chr_d;
  logic             char_str_q, char_str_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             printable;
  logic [7:0]       tab_sum;
  logic             do_nl;

  assign accept    = (state_q == ST_IDLE) && con.in_valid;
  assign printable = is_printable(con.in_data);
  // Next tab stop, kept at 8 bits so the last stop past column 79 does not wrap.
  assign tab_sum   = ({1'b0, cur_x_q} | TAB_MASK) + 8'd1;

  // State register.
  always_ff @(posedge clk_sys or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, cursor and clear-sequencer position.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    do_nl   = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = CLR_ON_RST ? ST_CLR_SCREEN : ST_IDLE;
        clr_x_d = '0;
        clr_y_d = '0;
      end

      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            if (cur_x_q == X_LAST) begin
              do_nl = 1'b1;
            end else begin
              cur_x_d = cur_x_q + X_W'(1);
            end
          end else begin
            case (con.in_data)
              CH_CR:  cur_x_d = '0;
              CH_LF:  do_nl = 1'b1;
              CH_BS: begin
                if (cur_x_q != '0) begin
                  cur_x_d = cur_x_q - X_W'(1);
                end
              end
              CH_TAB: begin
                if (tab_sum >= COLS_8) begin
                  do_nl = 1'b1;
                end else begin
                  cur_x_d = tab_sum[X_W-1:0];
                end
              end
              CH_FF: begin
                state_d = ST_CLR_SCREEN;
                clr_x_d = '0;
                clr_y_d = '0;
              end
              default: ;
            endcase
          end

          // Newline moves to the next row (wrapping to the top) and blanks it.
          if (do_nl) begin
            cur_x_d = '0;
            cur_y_d = (cur_y_q == Y_LAST) ? '0 : cur_y_q + Y_W'(1);
            state_d = ST_CLR_LINE;
            clr_x_d = '0;
          end
        end
      end

      ST_CLR_LINE: begin
        if (clr_x_q == X_END) begin
          state_d = ST_IDLE;
        end else begin
          clr_x_d = clr_x_q + X_W'(1);
        end
      end

      ST_CLR_SCREEN: begin
        if (clr_y_q == Y_END) begin
          state_d = ST_IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
        end else if (clr_x_q == X_LAST) begin
          clr_x_d = '0;
          clr_y_d = clr_y_q + Y_W'(1);
        end else begin
          clr_x_d = clr_x_q + X_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered write port and status outputs.
  always_comb begin
    char_x_d   = char_x_q;
    char_y_d   = char_y_q;
    char_chr_d = char_chr_q;
    char_str_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && printable) begin
          char_str_d = 1'b1;
          char_x_d   = cur_x_q;
          char_y_d   = cur_y_q;
          char_chr_d = {1'b0, con.in_data};
        end
      end
      ST_CLR_LINE: begin
        if (clr_x_q != X_END) begin
          char_str_d = 1'b1;
          char_x_d   = clr_x_q;
          char_y_d   = cur_y_q;
          char_chr_d = {1'b0, CH_SPACE};
        end
      end
      ST_CLR_SCREEN: begin
        if (clr_y_q != Y_END) begin
          char_str_d = 1'b1;
          char_x_d   = clr_x_q;
          char_y_d   = clr_y_q;
          char_chr_d = {1'b0, CH_SPACE};
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_CLR_LINE) || (state_d == ST_CLR_SCREEN);
  end

  // Cursor, sequencer and output registers.
  always_ff @(posedge clk_sys or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      clr_x_q    <= '0;
      clr_y_q    <= '0;
      char_x_q   <= '0;
      char_y_q   <= '0;
      char_chr_q <= '0;
      char_str_q <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      clr_x_q    <= clr_x_d;
      clr_y_q    <= clr_y_d;
      char_x_q   <= char_x_d;
      char_y_q   <= char_y_d;
      char_chr_q <= char_chr_d;
      char_str_q <= char_str_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign con.in_ready  = in_ready_q;
  assign con.char_x    = char_x_q;
  assign con.char_y    = char_y_q;
  assign con.char_chr  = char_chr_q;
  assign con.char_str  = char_str_q;
  assign con.cur_x     = cur_x_q;
  assign con.cur_y     = cur_y_q;
  assign con.busy      = busy_q;
  assign con.dbg_state = state_q;

endmodule
